// File: rtl/riscv_core_mem_arbiter.sv
// riscv_core_mem_arbiter
// Shares one memory port between the instruction fetch path and the data
// path. Requests go straight through combinationally with data given
// priority over fetch. An in-order tag FIFO remembers which requester owns
// each outstanding transaction so that responses, which come back in order,
// can be steered back to the right side.

module riscv_core_mem_arbiter #(
   parameter int p_depth = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_imemreq_val,
   output logic        o_imemreq_rdy,
   input  logic [31:0] i_imemreq_msg_addr,

   output logic        o_imemresp_val,
   input  logic        i_imemresp_rdy,
   output logic [31:0] o_imemresp_msg_data,

   input  logic        i_dmemreq_val,
   output logic        o_dmemreq_rdy,
   input  logic        i_dmemreq_msg_rw,
   input  logic [1:0]  i_dmemreq_msg_len,
   input  logic [31:0] i_dmemreq_msg_addr,
   input  logic [31:0] i_dmemreq_msg_data,

   output logic        o_dmemresp_val,
   input  logic        i_dmemresp_rdy,
   output logic [31:0] o_dmemresp_msg_data,

   output logic        o_memreq_val,
   input  logic        i_memreq_rdy,
   output logic        o_memreq_msg_rw,
   output logic [1:0]  o_memreq_msg_len,
   output logic [31:0] o_memreq_msg_addr,
   output logic [31:0] o_memreq_msg_data,

   input  logic        i_memresp_val,
   output logic        o_memresp_rdy,
   input  logic [31:0] i_memresp_msg_data,

   output logic        o_err_orphan_resp
);

   localparam int PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int CntW = PtrW + 1;

   // Owner of each outstanding transaction: 0 = fetch, 1 = data
   logic [p_depth-1:0] r_tags;
   logic [PtrW-1:0]    r_wrPtr;
   logic [PtrW-1:0]    r_rdPtr;
   logic [CntW-1:0]    r_count;
   logic               r_orphan;

   logic w_full;
   logic w_empty;
   logic w_grantOk;
   logic w_selDmem;
   logic w_head;
   logic w_push;
   logic w_pop;

   // A full tag FIFO blocks new grants even if a response drains it this
   // cycle; the grant decision looks only at the registered count.
   assign w_full    = (r_count == CntW'(p_depth));
   assign w_empty   = (r_count == '0);
   assign w_grantOk = !reset && !w_full;
   assign w_selDmem = i_dmemreq_val;
   assign w_head    = r_tags[r_rdPtr];

   assign o_memreq_val  = (i_dmemreq_val || i_imemreq_val) && w_grantOk;
   assign o_dmemreq_rdy = w_grantOk && i_memreq_rdy;
   assign o_imemreq_rdy = w_grantOk && i_memreq_rdy && !i_dmemreq_val;

   // Fetches are always full-word reads with no write data
   assign o_memreq_msg_rw   = w_selDmem ? i_dmemreq_msg_rw   : 1'b0;
   assign o_memreq_msg_len  = w_selDmem ? i_dmemreq_msg_len  : 2'd0;
   assign o_memreq_msg_addr = w_selDmem ? i_dmemreq_msg_addr : i_imemreq_msg_addr;
   assign o_memreq_msg_data = w_selDmem ? i_dmemreq_msg_data : 32'd0;

   assign o_imemresp_val = !reset && i_memresp_val && !w_empty && !w_head;
   assign o_dmemresp_val = !reset && i_memresp_val && !w_empty &&  w_head;
   assign o_imemresp_msg_data = i_memresp_msg_data;
   assign o_dmemresp_msg_data = i_memresp_msg_data;

   assign o_memresp_rdy = !reset && !w_empty && (w_head ? i_dmemresp_rdy : i_imemresp_rdy);

   assign w_push = o_memreq_val && i_memreq_rdy;
   assign w_pop  = i_memresp_val && o_memresp_rdy;

   assign o_err_orphan_resp = r_orphan;

   // Tag storage needs no reset; entries are only read when the count says valid
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_tags[r_wrPtr] <= w_selDmem;
      end
   end

   // FIFO pointers, occupancy and the sticky orphan-response flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_count  <= '0;
         r_orphan <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PtrW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
         if (i_memresp_val && w_empty) begin
            r_orphan <= 1'b1;
         end
      end
   end

endmodule
